// File: rtl/data_mem_sized.sv
// Byte-addressed single-port data memory with sized, sign/zero-extending loads and a 1-cycle registered response.
// Optional post-reset zero sweep enabled by defining DMEM_CLEAR_EN.
module data_mem_sized #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  localparam int OFF_W = $clog2(DATA_W / 8),
  localparam int BA_W  = ADDR_W + OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BA_W-1:0]   req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // state   | meaning
  // CLEAR   | zero sweep after reset, requests refused (DMEM_CLEAR_EN only)
  // IDLE    | accepting requests, req_ready high
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;
  localparam state_t ST_RST = S_CLEAR;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              w_clr_we;
`else
  typedef enum logic {S_IDLE = 1'b1} state_t;
  localparam state_t ST_RST = S_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [OFF_W-1:0]  w_off;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_sz_bytes;
  logic [6:0]        w_bits;
  logic              w_err;
  logic              w_accept;
  logic              w_st_we;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_ext;
  logic              w_sbit;
  logic              w_fill;

  assign w_off      = req_addr[OFF_W-1:0];
  assign w_idx      = req_addr[BA_W-1:OFF_W];
  assign w_sz_bytes = 4'd1 << req_size;
  assign w_bits     = 7'd8 << req_size;
  assign w_err      = (int'(w_sz_bytes) > NB) ||
                      ((w_off & OFF_W'(w_sz_bytes - 4'd1)) != '0);
  assign w_accept   = req_valid & r_ready;
  assign w_st_we    = w_accept & req_we & ~w_err & ~rst;
  assign w_lane     = req_wdata << {w_off, 3'b000};
  assign w_word     = r_mem[w_idx];

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_be[b] = (b >= int'(w_off)) && (b < int'(w_off) + int'(w_sz_bytes));
    end
  end

  // Extension bits come from the top bit of the selected field, not of the word.
  always_comb begin
    w_sh = w_word >> {w_off, 3'b000};
    case (req_size)
      2'd0:    w_sbit = w_sh[7];
      2'd1:    w_sbit = w_sh[15];
      2'd2:    w_sbit = w_sh[31];
      default: w_sbit = w_sh[DATA_W-1];
    endcase
    w_fill = req_signed & w_sbit;
    for (int i = 0; i < DATA_W; i++) begin
      w_ext[i] = (i < int'(w_bits)) ? w_sh[i] : w_fill;
    end
  end

`ifdef DMEM_CLEAR_EN
  assign w_clr_we = (r_state == S_CLEAR) & ~rst;
`endif

  always_comb begin
    w_state_nxt = r_state;
`ifdef DMEM_CLEAR_EN
    if (r_state == S_CLEAR && r_clr_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RST;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef DMEM_CLEAR_EN
      r_clr_ptr   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err | req_we) ? '0 : w_ext;
      end
`ifdef DMEM_CLEAR_EN
      if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
`endif
    end
  end

  // Memory is deliberately outside the reset branch so contents survive reset.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (w_clr_we) r_mem[r_clr_ptr] <= '0;
`endif
    for (int b = 0; b < NB; b++) begin
      if (w_st_we && w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_lane[b*8 +: 8];
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized (DATA_W=32, ADDR_W=5): directed cases plus random traffic
// checked against a byte-array memory model.
module tb_data_mem_sized;
  localparam int NB    = 4;
  localparam int DEPTH = 32;
`ifdef DMEM_CLEAR_EN
  localparam int RDY_LAT = DEPTH;
`else
  localparam int RDY_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [6:0]  req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_sized #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  byte unsigned mem_m [NB*DEPTH];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: little-endian byte array, natural alignment rule, extension by arithmetic.
  task automatic model(input logic we, input logic [6:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int n, off, base;
    logic [63:0] v;
    n    = 1 << sz;
    off  = int'(a) % NB;
    base = (int'(a) / NB) * NB;
    e    = (n > NB) || (off % n != 0);
    d    = '0;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_m[base + off + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(mem_m[base + off + k]) << (8*k));
        if (sg && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        d = v[31:0];
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d expected no response", cyc);
      end else begin
        e = q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        last_data = rsp_rdata;
      end
    end
  end

  task automatic issue(input logic we, input logic [6:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd);
    int   k = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_signed = sg; req_wdata = wd;
    while (req_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (req_ready !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1 within 100 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    model(we, a, sz, sg, wd, e.data, e.err);
    e.cyc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic release_and_wait(input string nm);
    int k = 0;
    rst = 1'b0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(nm, k, RDY_LAT);
  endtask

  task automatic model_reset();
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < NB*DEPTH; i++) mem_m[i] = 8'h00;
`endif
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    logic [6:0] a;
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    model_reset();
    release_and_wait("ready_after_reset");

`ifdef DMEM_CLEAR_EN
    for (int w = 0; w < DEPTH; w++) issue(1'b0, 7'(w*4), 2'd2, 1'b0, 32'd0);
    drain();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    release_and_wait("ready_after_mid_sweep_reset");
`endif

    // fill every word so later loads never touch unwritten memory
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 7'(w*4), 2'd2, 1'b0, $urandom);

    issue(1'b1, 7'h08, 2'd2, 1'b0, 32'hDEADBEEF);
    issue(1'b0, 7'h08, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_rdata_hold", rsp_rdata, last_data);

    issue(1'b1, 7'h0B, 2'd0, 1'b0, 32'h123456A5);
    issue(1'b0, 7'h08, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 7'h0B, 2'd0, 1'b1, 32'h0);
    issue(1'b0, 7'h0B, 2'd0, 1'b0, 32'h0);
    issue(1'b0, 7'h0A, 2'd1, 1'b1, 32'h0);

    issue(1'b0, 7'h09, 2'd1, 1'b0, 32'h0);
    issue(1'b1, 7'h0A, 2'd2, 1'b0, 32'hCAFEF00D);
    issue(1'b0, 7'h08, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 7'h08, 2'd3, 1'b0, 32'h0);

    issue(1'b1, 7'h7C, 2'd2, 1'b0, 32'h11111111);
    issue(1'b0, 7'h7C, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) issue(1'b0, 7'(i*4), 2'd2, 1'b1, 32'h0);
    drain();

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 7'($urandom);
      if ($urandom_range(0, 3) != 0) a = 7'(int'(a) & ~((1 << sz) - 1));
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    drain();

    // load response is already out; reset the following cycle with a request pending
    issue(1'b0, 7'h08, 2'd2, 1'b0, 32'h0);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h10; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    model_reset();
    release_and_wait("ready_after_second_reset");
    issue(1'b0, 7'h08, 2'd2, 1'b0, 32'h0);
    issue(1'b0, 7'h7C, 2'd2, 1'b0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
